// File: rtl/ncl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ncl_ctrl_pkg
// Brief   : Shared types and 1-of-W code helpers for the NCL ring supervisor.
// Rev     : 1.0  initial release
// ============================================================================
package ncl_ctrl_pkg;

    // Helpers take a fixed-width vector; callers zero-extend narrower taps.
    localparam int c_MAX_W = 64;
    localparam int c_MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STALL = 2'd3
    } ring_state_t;

    typedef enum logic [1:0] {
        CLS_NULL    = 2'd0,
        CLS_DATA    = 2'd1,
        CLS_ILLEGAL = 2'd2
    } tap_class_t;

    function automatic tap_class_t onehot_class(input logic [c_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < c_MAX_W; i++) begin
            n = n + int'(v[i]);
        end
        if (n == 0) begin
            return CLS_NULL;
        end else if (n == 1) begin
            return CLS_DATA;
        end else begin
            return CLS_ILLEGAL;
        end
    endfunction

    function automatic logic [c_MAX_IDX_W-1:0] onehot_idx(input logic [c_MAX_W-1:0] v);
        logic [c_MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if (v[i]) begin
                idx = c_MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_sync2.sv
`default_nettype none
// ============================================================================
// Module  : ncl_sync2
// Brief   : N-bit two-flop synchroniser, synchronous reset to zero.
// Rev     : 1.0  initial release
// ============================================================================
module ncl_sync2 #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/ncl_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ncl_ring_ctrl
// Brief   : Clocked supervisor for a self-timed 1-of-W NCL token ring:
//           init sequencing, wavefront counting, illegal-code and stall detect.
// Rev     : 1.0  initial release
// ============================================================================
module ncl_ring_ctrl
    import ncl_ctrl_pkg::*;
#(
    parameter int W           = 8,
    parameter int INIT_CYCLES = 60,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 start,
    input  logic                 auto_restart,
    input  logic [W-1:0]         tap_d,
    input  logic                 tap_k,
    output logic                 ring_init,
    output logic                 running,
    output logic                 stalled,
    output logic                 err_illegal,
    output logic [CNT_W-1:0]     token_cnt,
    output logic [$clog2(W)-1:0] last_idx,
    output logic                 last_vld
);

    localparam int c_IDX_W = $clog2(W);
    localparam int c_PH_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int c_WD_W  = $clog2(TIMEOUT);

    ring_state_t          r_state;
    tap_class_t           r_prev_class;
    logic [c_PH_W-1:0]    r_phase;
    logic [c_WD_W-1:0]    r_wd;
    logic                 r_k_prev;

    logic [W:0]             w_sync;
    logic [W-1:0]           w_tap_d;
    logic                   w_tap_k;
    logic [c_MAX_W-1:0]     w_tap_ext;
    logic [c_MAX_IDX_W-1:0] w_idx_full;
    logic                   w_unused;
    tap_class_t             w_class;
    logic                   w_k_edge;
    logic                   w_wd_expired;
    logic                   w_ph_done;
    logic                   w_enter_init;

    ncl_sync2 #(
        .N (W + 1)
    ) u_sync (
        .clk (clk),
        .rst (init),
        .i_d ({tap_k, tap_d}),
        .o_q (w_sync)
    );

    assign w_tap_d = w_sync[W-1:0];
    assign w_tap_k = w_sync[W];

    always_comb begin
        w_tap_ext        = '0;
        w_tap_ext[W-1:0] = w_tap_d;
    end

    assign w_class      = onehot_class(w_tap_ext);
    assign w_idx_full   = onehot_idx(w_tap_ext);
    assign w_unused     = ^w_idx_full;
    assign w_k_edge     = w_tap_k ^ r_k_prev;
    assign w_wd_expired = (r_wd == c_WD_W'(TIMEOUT - 1));
    assign w_ph_done    = (r_phase == c_PH_W'(INIT_CYCLES - 1));
    assign w_enter_init = ((r_state == ST_IDLE) && start) ||
                          ((r_state == ST_STALL) && (start || auto_restart));

    // Sequencer; ring_init/running/stalled are registered alongside the state.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            ring_init <= 1'b1;
            running   <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_INIT;
                        r_phase <= '0;
                    end
                end
                ST_INIT: begin
                    if (w_ph_done) begin
                        r_state   <= ST_RUN;
                        ring_init <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A fresh tap_k edge rescues an otherwise-expiring watchdog.
                    if (w_wd_expired && !w_k_edge) begin
                        r_state <= ST_STALL;
                        running <= 1'b0;
                        stalled <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (start || auto_restart) begin
                        r_state   <= ST_INIT;
                        r_phase   <= '0;
                        ring_init <= 1'b1;
                        stalled   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    ring_init <= 1'b1;
                    running   <= 1'b0;
                    stalled   <= 1'b0;
                end
            endcase
        end
    end

    // Tap monitor and watchdog.
    always_ff @(posedge clk) begin
        if (init) begin
            r_prev_class <= CLS_NULL;
            r_wd         <= '0;
            r_k_prev     <= 1'b0;
            err_illegal  <= 1'b0;
            token_cnt    <= '0;
            last_idx     <= '0;
            last_vld     <= 1'b0;
        end else begin
            r_k_prev <= w_tap_k;
            if (w_enter_init) begin
                r_prev_class <= CLS_NULL;
                r_wd         <= '0;
                err_illegal  <= 1'b0;
                token_cnt    <= '0;
                last_vld     <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_prev_class <= w_class;
                if (w_k_edge) begin
                    r_wd <= '0;
                end else if (!w_wd_expired) begin
                    r_wd <= r_wd + 1'b1;
                end
                if (w_class == CLS_ILLEGAL) begin
                    err_illegal <= 1'b1;
                end
                if ((w_class == CLS_DATA) && (r_prev_class == CLS_NULL)) begin
                    if (token_cnt != '1) begin
                        token_cnt <= token_cnt + 1'b1;
                    end
                    last_idx <= w_idx_full[c_IDX_W-1:0];
                    last_vld <= 1'b1;
                end
            end else begin
                r_prev_class <= CLS_NULL;
                r_wd         <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ncl_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ncl_ring_ctrl
// Brief   : Directed self-checking bench for ncl_ring_ctrl with a tap scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ncl_ring_ctrl;

    localparam int c_W    = 8;
    localparam int c_INIT = 60;
    localparam int c_TO   = 16;
    localparam int c_CW   = 4;

    logic            clk;
    logic            init;
    logic            start;
    logic            auto_restart;
    logic [c_W-1:0]  tap_d;
    logic            tap_k;
    logic            ring_init;
    logic            running;
    logic            stalled;
    logic            err_illegal;
    logic [c_CW-1:0] token_cnt;
    logic [2:0]      last_idx;
    logic            last_vld;

    ncl_ring_ctrl #(
        .W           (c_W),
        .INIT_CYCLES (c_INIT),
        .TIMEOUT     (c_TO),
        .CNT_W       (c_CW)
    ) dut (
        .clk          (clk),
        .init         (init),
        .start        (start),
        .auto_restart (auto_restart),
        .tap_d        (tap_d),
        .tap_k        (tap_k),
        .ring_init    (ring_init),
        .running      (running),
        .stalled      (stalled),
        .err_illegal  (err_illegal),
        .token_cnt    (token_cnt),
        .last_idx     (last_idx),
        .last_vld     (last_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [c_CW-1:0] cnt;
        logic [2:0]      idx;
        logic            vld;
        logic            err;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int kcnt  = 0;
    int kper  = 4;
    int t_last = 0;
    bit ktog  = 1'b0;

    logic [c_CW-1:0] m_cnt;
    logic [2:0]      m_idx;
    logic            m_vld;
    logic            m_err;
    int              m_prev;   // 0 null, 1 data, 2 illegal

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ktog) begin
            kcnt++;
            if (kcnt >= kper) begin
                kcnt   = 0;
                tap_k  = ~tap_k;
                t_last = cyc;
            end
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("sb_cnt", 32'(token_cnt), 32'(e.cnt));
            check("sb_idx", 32'(last_idx), 32'(e.idx));
            check("sb_vld", 32'(last_vld), 32'(e.vld));
            check("sb_err", 32'(err_illegal), 32'(e.err));
        end
    endtask

    function automatic int cls(input logic [c_W-1:0] v);
        int n;
        n = $countones(v);
        return (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    endfunction

    function automatic logic [2:0] idx_of(input logic [c_W-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < c_W; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Old values must still show 2 edges after the drive; new ones land at 3.
    task automatic drive(input logic [c_W-1:0] v);
        int c;
        q.push_back('{cyc + 2, m_cnt, m_idx, m_vld, m_err});
        c = cls(v);
        if (c == 2) m_err = 1'b1;
        if (c == 1 && m_prev == 0) begin
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
            m_idx = idx_of(v);
            m_vld = 1'b1;
        end
        m_prev = c;
        q.push_back('{cyc + 3, m_cnt, m_idx, m_vld, m_err});
        tap_d = v;
    endtask

    task automatic model_init();
        m_cnt  = '0;
        m_vld  = 1'b0;
        m_err  = 1'b0;
        m_prev = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        check("sb_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_init_done(input string tag);
        for (int i = 1; i < c_INIT; i++) begin
            tick();
            check({tag, "_hold"}, {30'd0, ring_init, running}, 32'b10);
        end
        tick();
        check({tag, "_run"}, {29'd0, ring_init, running, stalled}, 32'b010);
    endtask

    initial begin
        bit saw_stall;
        bit saw_norun;
        bit found;
        int t_ref;

        init = 1'b1; start = 1'b0; auto_restart = 1'b0; tap_d = '0; tap_k = 1'b0;
        model_init();
        m_idx = 3'd0;
        @(negedge clk);
        repeat (3) tick();
        check("rst_ctl", {29'd0, ring_init, running, stalled}, 32'b100);
        check("rst_mon", {24'd0, err_illegal, token_cnt, last_idx, last_vld}, 32'd0);

        // Test 1: init sequencing
        init = 1'b0;
        ktog = 1'b1;
        tick();
        check("idle_ring_init", 32'(ring_init), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("init_entry", {30'd0, ring_init, running}, 32'b10);
        wait_init_done("init1");
        check("run_cnt0", 32'(token_cnt), 32'd0);

        // Test 2: wavefront counting with latency
        repeat (4) tick();
        drive(8'h00); repeat (4) tick();
        drive(8'h04); repeat (4) tick();
        drive(8'h00); repeat (4) tick();
        drive(8'h10); repeat (4) tick();
        drain();
        check("t2_cnt", 32'(token_cnt), 32'd2);
        check("t2_idx", 32'(last_idx), 32'd4);
        check("t2_vld", 32'(last_vld), 32'd1);

        // Test 3: illegal code is sticky and does not count
        drive(8'h09); repeat (4) tick();
        drive(8'h00); repeat (6) tick();
        drain();
        check("t3_err_sticky", 32'(err_illegal), 32'd1);
        check("t3_cnt", 32'(token_cnt), 32'd2);

        // Test 4: stall after TIMEOUT quiet cycles, then restart
        ktog = 1'b0;
        t_ref = t_last;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (stalled) found = 1'b1;
        end
        check("t4_stall_seen", 32'(found), 32'd1);
        check("t4_stall_cycle", 32'(cyc), 32'(t_ref + 19));
        check("t4_stall_ctl", {29'd0, ring_init, running, stalled}, 32'b001);
        repeat (5) tick();
        check("t4_stall_hold", 32'(stalled), 32'd1);
        check("t4_err_hold", 32'(err_illegal), 32'd1);
        start = 1'b1;
        auto_restart = 1'b1;
        tick();
        start = 1'b0;
        auto_restart = 1'b0;
        model_init();
        check("t4_reinit_ctl", {29'd0, ring_init, running, stalled}, 32'b100);
        check("t4_reinit_cnt", 32'(token_cnt), 32'd0);
        check("t4_reinit_err", 32'(err_illegal), 32'd0);
        check("t4_reinit_vld", 32'(last_vld), 32'd0);
        check("t4_idx_kept", 32'(last_idx), 32'd4);
        kper = 10;
        kcnt = 0;
        ktog = 1'b1;
        wait_init_done("init2");

        // Test 5: slow tap_k keeps watchdog alive; start ignored in RUN
        saw_stall = 1'b0;
        saw_norun = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) start = 1'b1;
            tick();
            start = 1'b0;
            if (i == 500) check("t5_start_ign", {30'd0, ring_init, running}, 32'b01);
            saw_stall = saw_stall | stalled;
            saw_norun = saw_norun | ~running;
        end
        check("t5_no_stall", 32'(saw_stall), 32'd0);
        check("t5_kept_run", 32'(saw_norun), 32'd0);

        // Test 6: counter saturation, then init mid-RUN
        kper = 4;
        kcnt = 0;
        for (int n = 0; n < 19; n++) begin
            drive(8'h01 << (n % 8)); repeat (4) tick();
            drive(8'h00);            repeat (4) tick();
        end
        drain();
        check("t6_sat", 32'(token_cnt), 32'd15);
        init = 1'b1;
        tick();
        check("t6_rst_ctl", {29'd0, ring_init, running, stalled}, 32'b100);
        check("t6_rst_mon", {24'd0, err_illegal, token_cnt, last_idx, last_vld}, 32'd0);
        init = 1'b0;
        ktog = 1'b0;
        tick();
        check("t6_idle", {29'd0, ring_init, running, stalled}, 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
